s386_event_capture: RTL and testbench
=====================================

// Module: s386_event_capture
// PURPOSE
//  Downstream observer for the s386 controller. Samples its 7-bit output vector
//  (v13_D_12..v13_D_6) every cycle and detects any change. Each change is pushed
//  as a timestamped event into a small FIFO, which a consumer drains over a
//  valid/ready handshake. Used in test harnesses and on-chip trace of the
//  controller's output sequence.
// PARAMETERS
//  DATA_W  7   width of observed vector (s386 output count)
//  TS_W    10  timestamp width; wraps modulo 2**TS_W
//  DEPTH   8   FIFO entries; power of 2, >= 2
// PORTS
//  CK         in   1               clock; every register in this block updates on rising edge
//  RST        in   1               synchronous reset, active-high
//  cap_en     in   1               capture enable
//  obs_d      in   DATA_W          observed vector {v13_D_12..v13_D_6}
//  ev_valid   out  1               FIFO head entry is valid
//  ev_ready   in   1               consumer accepts head this cycle
//  ev_data    out  TS_W+DATA_W     {timestamp, vector} at FIFO head
//  fifo_level out  $clog2(DEPTH)+1 number of entries currently held
//  overflow   out  1               sticky: an event was dropped
//  drop_cnt   out  8               dropped events, saturates at 255
// BEHAVIOUR
//  - Interface: one clock CK, synchronous active-high RST. The s386 flops
//    update on the falling CK edge, so obs_d is stable by the next rising edge.
//  - RST: state=IDLE; ts=0; last=0; FIFO empty; ev_valid=0; ev_data=0;
//    fifo_level=0; overflow=0; drop_cnt=0. RST overrides every other input.
//  - FSM IDLE -> PRIME -> RUN:
//    IDLE : no capture, ts is held. cap_en=1 -> PRIME, and ts is cleared to 0.
//    PRIME: one cycle. Loads last<=obs_d, ts+=1, and never pushes -> RUN.
//    RUN  : ts+=1 each cycle. If obs_d!=last, push {ts,obs_d} and set last<=obs_d.
//    cap_en=0 in PRIME or RUN -> IDLE on the next edge. No push happens on that
//    edge. Entries already in the FIFO are kept and can still be drained.
//  - Timestamp: the pushed ts is the counter value before the edge's increment.
//    The counter wraps from 2**TS_W-1 to 0 with no flag.
//  - Latency: a change first sampled at edge N is at the head by edge N if the
//    FIFO was empty, so ev_valid=1 in cycle N+1.
//  - Handshake: a pop occurs when ev_valid && ev_ready. ev_data is stable while
//    ev_valid=1 && ev_ready=0. ev_ready while empty has no effect.
//  - Full: a push with no pop in the same cycle is dropped. overflow<=1 and
//    drop_cnt increments, saturating at 255. last is still updated.
//  - Full with push and pop in the same cycle: both happen, the push is not
//    dropped and the level is unchanged.
//  - Empty with push only: the level becomes 1. Push and pop are never both
//    possible from empty, because data is not bypassed.
//  - overflow and drop_cnt clear only on RST.
//  - fifo_level = entries held after the edge. Range is 0..DEPTH.
// CONFIGURATION
//  S386_CAPTURE_MASK_EN defined: adds input port cap_mask[DATA_W-1:0]. An event
//    is pushed only if ((obs_d^last)&cap_mask)!=0. The pushed vector is the
//    full obs_d. last always tracks obs_d in RUN.
//  Undefined: the port is absent and any bit change pushes, as if cap_mask were
//    all ones.
// TESTING
//  1. RST 2 cycles, then cap_en=1 with obs_d held at 7'h00 for 20 cycles
//     -> ev_valid stays 0, fifo_level=0.
//  2. In RUN, obs_d goes 00->41 at ts=5 and 41->03 at ts=6, ev_ready=1
//     -> events {5,41} then {6,03}, in order, each delivered one cycle after
//     its change.
//  3. ev_ready=0, DEPTH=8, 10 changes -> fifo_level=8, overflow=1, drop_cnt=2.
//     Then hold ev_ready=1 -> the first 8 events drain in order.
//  4. FIFO full, change arrives with ev_ready=1 in the same cycle
//     -> fifo_level stays 8 and drop_cnt is unchanged.
//  5. TS_W=4: change at ts=15 and again two cycles later -> timestamps 15 and 1.
//  6. RST asserted with 3 entries queued -> next cycle ev_valid=0, fifo_level=0,
//     state IDLE. With S386_CAPTURE_MASK_EN and cap_mask=7'h01, a change
//     00->02 pushes nothing; 02->03 pushes {ts,03}.

Source files
------------

// File: rtl/s386_event_capture.sv
// Change-detecting observer for the s386 output vector: timestamps each change and queues it in a FIFO.
// Optional S386_CAPTURE_MASK_EN adds cap_mask to select which bits can trigger an event.
module s386_event_capture #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned TS_W   = 10,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic                     cap_en,
    input  logic [DATA_W-1:0]        obs_d,
`ifdef S386_CAPTURE_MASK_EN
    input  logic [DATA_W-1:0]        cap_mask,
`endif
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W+DATA_W-1:0]   ev_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = TS_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t            state, state_nx;
    logic [TS_W-1:0]   ts, ts_nx;
    logic [DATA_W-1:0] last, last_nx;
    logic [DATA_W-1:0] mask;
    logic              change;
    logic              push_req;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, pop, do_push, drop;

`ifdef S386_CAPTURE_MASK_EN
    assign mask = cap_mask;
`else
    assign mask = '1;
`endif

    assign change = |((obs_d ^ last) & mask);

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            ts    <= '0;
            last  <= '0;
        end else begin
            state <= state_nx;
            ts    <= ts_nx;
            last  <= last_nx;
        end
    end

    // Leaving PRIME/RUN freezes ts and last; the exit edge never pushes.
    always_comb begin
        state_nx = state;
        ts_nx    = ts;
        last_nx  = last;
        push_req = 1'b0;
        case (state)
            IDLE: begin
                if (cap_en) begin
                    state_nx = PRIME;
                    ts_nx    = '0;
                end
            end
            PRIME: begin
                if (!cap_en) begin
                    state_nx = IDLE;
                end else begin
                    last_nx  = obs_d;
                    ts_nx    = ts + TS_W'(1);
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!cap_en) begin
                    state_nx = IDLE;
                end else begin
                    last_nx  = obs_d;
                    ts_nx    = ts + TS_W'(1);
                    push_req = change;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ev_valid   = (count != '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign pop        = ev_valid && ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign ev_data    = ev_valid ? mem[rd_ptr] : '0;
    assign fifo_level = count;

    always_ff @(posedge CK) begin
        if (!RST && do_push) begin
            mem[wr_ptr] <= {ts, obs_d};
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_s386_event_capture.sv
// Bench for s386_event_capture: directed scenarios plus random traffic against a queue-based model.
// Build with S386_CAPTURE_MASK_EN defined to also exercise the capture mask.
module tb_s386_event_capture;

    localparam int DATA_W = 7;
    localparam int TS_W   = 4;
    localparam int DEPTH  = 8;
    localparam int EW     = TS_W + DATA_W;

    logic              CK = 1'b0;
    logic              RST;
    logic              cap_en;
    logic [DATA_W-1:0] obs_d;
`ifdef S386_CAPTURE_MASK_EN
    logic [DATA_W-1:0] cap_mask;
`endif
    logic              ev_valid;
    logic              ev_ready;
    logic [EW-1:0]     ev_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: capture phase, timestamp, last vector, event queue, drop bookkeeping.
    int            m_phase;   // 0 idle, 1 first enabled cycle, 2 capturing
    int            m_ts;
    logic [DATA_W-1:0] m_last;
    logic [EW-1:0] m_q[$];
    bit            m_ovf;
    int            m_drops;

    always #5 CK = ~CK;

    s386_event_capture #(
        .DATA_W(DATA_W),
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .cap_en    (cap_en),
        .obs_d     (obs_d),
`ifdef S386_CAPTURE_MASK_EN
        .cap_mask  (cap_mask),
`endif
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_data   (ev_data),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT, then compare.
    task automatic step();
        logic [DATA_W-1:0] msk;
        logic [EW-1:0]     ev;
        bit                pop, full, push;
        msk = '1;
`ifdef S386_CAPTURE_MASK_EN
        msk = cap_mask;
`endif
        ev = '0;
        if (RST) begin
            m_phase = 0;
            m_ts    = 0;
            m_last  = '0;
            m_q.delete();
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            pop  = (m_q.size() > 0) && ev_ready;
            full = (m_q.size() == DEPTH);
            push = 0;
            if (m_phase == 0) begin
                if (cap_en) begin
                    m_phase = 1;
                    m_ts    = 0;
                end
            end else if (!cap_en) begin
                m_phase = 0;
            end else begin
                if (m_phase == 2 && ((obs_d ^ m_last) & msk) != 0) begin
                    push = 1;
                    ev   = {TS_W'(m_ts), obs_d};
                end
                m_last  = obs_d;
                m_ts    = (m_ts + 1) % (1 << TS_W);
                m_phase = 2;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (full && !pop) begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_q.push_back(ev);
                end
            end
        end
        @(posedge CK);
        #1;
        chk("ev_valid",   32'(ev_valid),   32'(m_q.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("ev_data",    32'(ev_data),    (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("drop_cnt",   32'(drop_cnt),   32'(m_drops));
    endtask

    // Reset for two cycles, then enable: after this returns the block is capturing with ts=1.
    task automatic start();
        RST      = 1'b1;
        cap_en   = 1'b0;
        obs_d    = '0;
        ev_ready = 1'b0;
        step();
        step();
        RST    = 1'b0;
        cap_en = 1'b1;
        step();
        step();
    endtask

    task automatic new_obs();
        obs_d = obs_d ^ DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
    endtask

    initial begin
        RST      = 1'b1;
        cap_en   = 1'b0;
        obs_d    = '0;
        ev_ready = 1'b0;
`ifdef S386_CAPTURE_MASK_EN
        cap_mask = '1;
`endif
        m_phase = 0; m_ts = 0; m_last = '0; m_ovf = 0; m_drops = 0;

        // Reset state and a constant vector: nothing is ever queued.
        step();
        step();
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_data",  32'(ev_data), 32'd0);
        RST    = 1'b0;
        cap_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ev_ready = 1'($urandom_range(0, 1));
            step();
            chk("quiet_valid", 32'(ev_valid), 32'd0);
        end

        // Two changes at ts=5 and ts=6, consumer always ready.
        start();
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        obs_d = 7'h41;
        step();
        chk("ev0_data", 32'(ev_data), 32'({4'd5, 7'h41}));
        obs_d = 7'h03;
        step();
        chk("ev1_data", 32'(ev_data), 32'({4'd6, 7'h03}));
        step();
        chk("ev_drained", 32'(ev_valid), 32'd0);

        // Ten changes with no consumer: eight kept, two dropped, then drained in order.
        start();
        for (int i = 0; i < 10; i++) begin
            new_obs();
            step();
        end
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ovf",   32'(overflow), 32'd1);
        chk("full_drops", 32'(drop_cnt), 32'd2);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("drain_level", 32'(fifo_level), 32'd0);

        // Full FIFO with simultaneous push and pop loses nothing.
        start();
        for (int i = 0; i < 8; i++) begin
            new_obs();
            step();
        end
        new_obs();
        ev_ready = 1'b1;
        step();
        chk("pp_level", 32'(fifo_level), 32'd8);
        chk("pp_drops", 32'(drop_cnt), 32'd0);
        chk("pp_ovf",   32'(overflow), 32'd0);

        // Timestamp wrap: changes at ts=15 and two cycles later at ts=1.
        start();
        for (int i = 0; i < 14; i++) step();
        obs_d = 7'h15;
        step();
        chk("wrap_ts15", 32'(ev_data), 32'({4'd15, 7'h15}));
        step();
        obs_d = 7'h2A;
        step();
        chk("wrap_level", 32'(fifo_level), 32'd2);
        ev_ready = 1'b1;
        step();
        chk("wrap_ts1", 32'(ev_data), 32'({4'd1, 7'h2A}));

        // Reset with three entries queued clears the FIFO and restarts from idle.
        start();
        for (int i = 0; i < 3; i++) begin
            new_obs();
            step();
        end
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        RST = 1'b1;
        step();
        chk("post_rst_valid", 32'(ev_valid), 32'd0);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        RST = 1'b0;
        new_obs();
        step();
        new_obs();
        step();
        chk("restart_nopush", 32'(fifo_level), 32'd0);

`ifdef S386_CAPTURE_MASK_EN
        // Only bit 0 may trigger; the pushed vector is still the full observation.
        start();
        cap_mask = 7'h01;
        obs_d    = 7'h02;
        step();
        chk("mask_blocked", 32'(fifo_level), 32'd0);
        obs_d = 7'h03;
        step();
        chk("mask_pass", 32'(ev_data), 32'({4'd2, 7'h03}));
        cap_mask = '1;
`endif

        // Drop counter saturation.
        start();
        for (int i = 0; i < 280; i++) begin
            new_obs();
            step();
        end
        chk("sat_drops", 32'(drop_cnt), 32'd255);

        // Random traffic including enable drops and occasional resets.
        start();
        for (int i = 0; i < 2000; i++) begin
            RST      = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) cap_en = ~cap_en;
            ev_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) new_obs();
`ifdef S386_CAPTURE_MASK_EN
            if ((i % 50) == 0) cap_mask = DATA_W'($urandom);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
